// File: rtl/vga_timing_gen.sv
// VGA raster timing and test-pattern generator; outputs registered one pixel tick after the counters.
// Free-running with no backpressure: pixels are produced every tick regardless of the consumer.
module vga_timing_gen #(
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [RW-1:0] ext_r,
    input  logic [GW-1:0] ext_g,
    input  logic [BW-1:0] ext_b,
    output logic [RW-1:0] red,
    output logic [GW-1:0] green,
    output logic [BW-1:0] blue,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [5:0]    frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 6 bits so the checkerboard can always look at bit 5.
    localparam int HW = ($clog2(H_TOTAL) + 1 > 6) ? $clog2(H_TOTAL) + 1 : 6;
    localparam int VW = ($clog2(V_TOTAL) + 1 > 6) ? $clog2(V_TOTAL) + 1 : 6;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] BAR_W    = HW'(BAR);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [1:0]    act_mode;

    logic          tick;
    logic          line_end;
    logic          frame_end;
    logic          frame_start;
    logic [1:0]    cur_mode;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic [HW-1:0] bar_idx;
    logic [2:0]    bar3;
    logic [2:0]    bar_c;
    logic [RW-1:0] r_c;
    logic [GW-1:0] g_c;
    logic [BW-1:0] b_c;

    always_comb begin
        tick        = (div == DIV_LAST);
        line_end    = (hcount == H_LAST);
        frame_end   = (vcount == V_LAST);
        frame_start = (hcount == '0) && (vcount == '0);
        // The pattern for the first pixel of a frame already uses the newly latched mode.
        cur_mode    = frame_start ? mode : act_mode;
        de_c        = (hcount < H_ACT) && (vcount < V_ACT);
        hs_c        = (hcount >= HS_START && hcount <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_c        = (vcount >= VS_START && vcount <= VS_END) ? SYNC_POL : ~SYNC_POL;
        bar_idx     = hcount / BAR_W;
        bar3        = (bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0];
        bar_c       = 3'd7 - bar3;
        r_c         = '0;
        g_c         = '0;
        b_c         = '0;
        case (cur_mode)
            2'd0: begin
                r_c = '1;
                g_c = '1;
                b_c = '1;
            end
            2'd1: begin
                r_c = {RW{bar_c[2]}};
                g_c = {GW{bar_c[1]}};
                b_c = {BW{bar_c[0]}};
            end
            2'd2: begin
                r_c = {RW{~(hcount[5] ^ vcount[5])}};
                g_c = {GW{~(hcount[5] ^ vcount[5])}};
                b_c = {BW{~(hcount[5] ^ vcount[5])}};
            end
            default: begin
                r_c = ext_r;
                g_c = ext_g;
                b_c = ext_b;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
            act_mode  <= 2'd0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            de        <= 1'b0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (frame_start) begin
                    act_mode <= mode;
                end
                hcount <= line_end ? '0 : hcount + 1'b1;
                if (line_end) begin
                    vcount <= frame_end ? '0 : vcount + 1'b1;
                    if (frame_end) begin
                        frame_cnt <= frame_cnt + 6'd1;
                    end
                end
                red   <= de_c ? r_c : '0;
                green <= de_c ? g_c : '0;
                blue  <= de_c ? b_c : '0;
                de    <= de_c;
                hsync <= hs_c;
                vsync <= vs_c;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny CLK_DIV=1 instance, each checked every clock against a raster model.
module tb_vga_timing_gen;
    localparam int FT_D = 800 * 525;
    localparam int FT_S = 12 * 7;

    logic       clk;
    logic       rst_d, rst_s;
    logic [1:0] mode_d, mode_s;
    logic [2:0] ext_r, ext_g;
    logic [1:0] ext_b;

    logic [2:0] red_d, green_d, red_s, green_s;
    logic [1:0] blue_d, blue_s;
    logic       hsync_d, vsync_d, de_d, hsync_s, vsync_s, de_s;
    logic [5:0] frame_d, frame_s;

    int total = 0;
    int bad   = 0;
    int clk_n = 0;
    bit go    = 0;

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst_d), .mode(mode_d),
        .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
        .red(red_d), .green(green_d), .blue(blue_d),
        .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .frame_cnt(frame_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .mode(mode_s),
        .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
        .red(red_s), .green(green_s), .blue(blue_s),
        .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .frame_cnt(frame_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        clk_n += n;
    endtask

    // Pixel at raster position pos of a frame: {red, green, blue, hsync, vsync, de}.
    function automatic logic [10:0] expect_px(
        input int ha, input int hf, input int hsw, input int hb,
        input int va, input int vf, input int vsw,
        input bit pol, input int pos, input logic [1:0] m,
        input logic [2:0] er, input logic [2:0] eg, input logic [1:0] eb);
        int ht, h, v, b, bw;
        logic [2:0] r, g, cc;
        logic [1:0] bl;
        logic       de, hs, vs;
        ht = ha + hf + hsw + hb;
        h  = pos % ht;
        v  = pos / ht;
        de = (h < ha) && (v < va);
        hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : !pol;
        vs = (v >= va + vf && v < va + vf + vsw) ? pol : !pol;
        r = 3'd0; g = 3'd0; bl = 2'd0;
        case (m)
            2'd0: begin r = 3'd7; g = 3'd7; bl = 2'd3; end
            2'd1: begin
                bw = (ha / 8 > 0) ? ha / 8 : 1;
                b  = h / bw;
                if (b > 7) b = 7;
                cc = 3'(7 - b);
                r  = cc[2] ? 3'd7 : 3'd0;
                g  = cc[1] ? 3'd7 : 3'd0;
                bl = cc[0] ? 2'd3 : 2'd0;
            end
            2'd2: if (((h / 32) % 2) == ((v / 32) % 2)) begin r = 3'd7; g = 3'd7; bl = 2'd3; end
            default: begin r = er; g = eg; bl = eb; end
        endcase
        if (!de) begin r = 3'd0; g = 3'd0; bl = 2'd0; end
        return {r, g, bl, hs, vs, de};
    endfunction

    int          cs_d, k_d, cs_s, k_s;
    logic [1:0]  mm_d, mm_s;
    logic [10:0] px_d, px_s;

    always @(posedge clk) begin
        if (rst_d) begin
            cs_d = 0; k_d = 0; px_d = {8'h00, 1'b1, 1'b1, 1'b0};
        end else begin
            cs_d++;
            if (cs_d % 2 == 0) begin
                if (k_d % FT_D == 0) mm_d = mode_d;
                px_d = expect_px(640, 16, 96, 48, 480, 10, 2, 1'b0, k_d % FT_D, mm_d, ext_r, ext_g, ext_b);
                k_d++;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_s) begin
            cs_s = 0; k_s = 0; px_s = {8'h00, 1'b0, 1'b0, 1'b0};
        end else begin
            cs_s++;
            if (k_s % FT_S == 0) mm_s = mode_s;
            px_s = expect_px(8, 1, 2, 1, 4, 1, 1, 1'b1, k_s % FT_S, mm_s, ext_r, ext_g, ext_b);
            k_s++;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("model_default", {red_d, green_d, blue_d, hsync_d, vsync_d, de_d, frame_d},
                {px_d, 6'((k_d / FT_D) % 64)});
            chk("model_small", {red_s, green_s, blue_s, hsync_s, vsync_s, de_s, frame_s},
                {px_s, 6'((k_s / FT_S) % 64)});
        end
    end

    initial begin
        int lows, des, hs_line, hs_all, vs_all, nfall, fall0, fall1;
        logic prev;
        rst_d = 1'b1; rst_s = 1'b1;
        mode_d = 2'd1; mode_s = 2'd1;
        ext_r = 3'd1; ext_g = 3'd6; ext_b = 2'd2;
        repeat (5) @(posedge clk);
        @(negedge clk);
        go = 1'b1;
        chk("reset_default", {red_d, green_d, blue_d, hsync_d, vsync_d, de_d, frame_d}, {8'h00, 1'b1, 1'b1, 1'b0, 6'd0});
        chk("reset_small", {hsync_s, vsync_s, de_s}, {1'b0, 1'b0, 1'b0});

        rst_d = 1'b0; rst_s = 1'b0; clk_n = 0;
        adv(1);
        chk("no_tick_clk1", {de_d, red_d}, {1'b0, 3'd0});
        adv(1);
        chk("first_tick_bar0", {red_d, green_d, blue_d, de_d}, {3'd7, 3'd7, 2'd3, 1'b1});
        adv(162 - clk_n);
        chk("x80_bar1", {red_d, green_d, blue_d, de_d}, {3'd7, 3'd7, 2'd0, 1'b1});
        adv(1122 - clk_n);
        chk("x560_bar7", {red_d, green_d, blue_d, de_d}, {3'd0, 3'd0, 2'd0, 1'b1});

        lows = 0; des = 0; nfall = 0; fall0 = 0; fall1 = 0; prev = hsync_d;
        for (int i = 0; i < 3200; i++) begin
            adv(1);
            if (i < 1600 && !hsync_d) lows++;
            if (i < 1600 && de_d) des++;
            if (prev && !hsync_d) begin
                if (nfall == 0) fall0 = clk_n; else if (nfall == 1) fall1 = clk_n;
                nfall++;
            end
            prev = hsync_d;
        end
        chk("hsync_low_clks", lows, 192);
        chk("de_high_clks", des, 1280);
        chk("hsync_first_fall", fall0, 1314);
        chk("hsync_period", fall1 - fall0, 1600);

        adv(5402 - clk_n);
        chk("pre_reset_x300", {red_d, green_d, blue_d, de_d}, {3'd7, 3'd0, 2'd0, 1'b1});
        rst_d = 1'b1;
        adv(1);
        chk("midline_reset", {red_d, green_d, blue_d, hsync_d, vsync_d, de_d, frame_d}, {8'h00, 1'b1, 1'b1, 1'b0, 6'd0});
        rst_d = 1'b0; clk_n = 0;
        adv(1);
        chk("restart_clk1", {de_d, hsync_d}, {1'b0, 1'b1});
        adv(1);
        chk("restart_tick", {red_d, green_d, blue_d, de_d}, {3'd7, 3'd7, 2'd3, 1'b1});

        rst_s = 1'b1;
        adv(1);
        rst_s = 1'b0; clk_n = 0;
        adv(1);
        chk("small_first_px", {red_s, green_s, blue_s, de_s}, {3'd7, 3'd7, 2'd3, 1'b1});
        hs_line = 0; hs_all = 0; vs_all = 0;
        for (int i = 0; i < 84; i++) begin
            if (i < 12 && hsync_s) hs_line++;
            if (hsync_s) hs_all++;
            if (vsync_s) vs_all++;
            adv(1);
        end
        chk("small_hsync_line", hs_line, 2);
        chk("small_hsync_frame", hs_all, 14);
        chk("small_vsync_frame", vs_all, 12);
        chk("small_frame1", frame_s, 6'd1);
        adv(97 - clk_n);
        mode_s = 2'd2;
        adv(104 - clk_n);
        chk("bars_persist", {red_s, green_s, blue_s, de_s}, {3'd0, 3'd0, 2'd0, 1'b1});
        adv(176 - clk_n);
        chk("checker_next_frame", {red_s, green_s, blue_s, de_s}, {3'd7, 3'd7, 2'd3, 1'b1});
        adv(5375 - clk_n);
        chk("frame_63", frame_s, 6'd63);
        adv(1);
        chk("frame_wrap", frame_s, 6'd0);
        mode_s = 2'd3; ext_r = 3'd5; ext_g = 3'd2; ext_b = 2'd1;
        adv(1);
        chk("ext_passthru", {red_s, green_s, blue_s, de_s}, {3'd5, 3'd2, 2'd1, 1'b1});
        mode_s = 2'd0;
        adv(5461 - clk_n);
        chk("solid_white", {red_s, green_s, blue_s, de_s}, {3'd7, 3'd7, 2'd3, 1'b1});
        adv(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
